// File: rtl/register_block_sequencer.sv
// Command-driven master for a registered-read register block: one command per
// handshake, drives the block's port-side strobes and returns a result on rsp_*.
module register_block_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REGS   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_src,
    input  logic [ADDR_WIDTH-1:0] cmd_dst,
    input  logic [DATA_WIDTH-1:0] cmd_imm,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_error,
    output logic                  rb_write_enable,
    output logic                  rb_read_enable,
    output logic [ADDR_WIDTH-1:0] rb_src_reg,
    output logic [ADDR_WIDTH-1:0] rb_dst_reg,
    output logic [DATA_WIDTH-1:0] rb_input_bus,
    input  logic [DATA_WIDTH-1:0] rb_output_bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RSP  = 3'd4;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_MOVE = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    logic [2:0]            state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic                  bad;

    function automatic logic idx_bad(input logic [ADDR_WIDTH-1:0] idx);
        return 32'(idx) >= 32'(NUM_REGS);
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        err_d   = err_q;
        bad     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_LOAD: bad = idx_bad(cmd_dst);
                        OP_MOVE: bad = idx_bad(cmd_src) || idx_bad(cmd_dst);
                        OP_READ: bad = idx_bad(cmd_src);
                        default: bad = 1'b0;
                    endcase
                    op_d   = cmd_op;
                    err_d  = bad;
                    data_d = '0;
                    // Rejected and NOP commands leave the block-side address lines untouched.
                    if (bad || cmd_op == OP_NOP) begin
                        state_d = S_RSP;
                    end else begin
                        src_d = cmd_src;
                        dst_d = cmd_dst;
                        if (cmd_op == OP_LOAD) begin
                            data_d  = cmd_imm;
                            state_d = S_WR;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                end
            end
            S_RD:  state_d = S_CAP;
            S_CAP: begin
                // The block presents read data only during the cycle after read_enable.
                data_d  = rb_output_bus;
                state_d = (op_q == OP_MOVE) ? S_WR : S_RSP;
            end
            S_WR:  state_d = S_RSP;
            S_RSP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Reset forces state_q to IDLE, so cmd_ready must also be masked by rst itself.
    assign cmd_ready       = (state_q == S_IDLE) && !rst;
    assign rsp_valid       = (state_q == S_RSP);
    assign rsp_data        = (state_q == S_RSP) ? data_q : '0;
    assign rsp_error       = (state_q == S_RSP) && err_q;
    assign rb_write_enable = (state_q == S_WR);
    assign rb_read_enable  = (state_q == S_RD);
    assign rb_src_reg      = src_q;
    assign rb_dst_reg      = dst_q;
    assign rb_input_bus    = data_q;

endmodule

// File: tb/tb_register_block_sequencer.sv
// Self-checking bench: sequencer driving a behavioural 6x8 register block,
// compared against a command-level reference model.
module tb_register_block_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_src = 3'd0;
    logic [2:0] cmd_dst = 3'd0;
    logic [7:0] cmd_imm = 8'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_error;
    logic       rb_write_enable;
    logic       rb_read_enable;
    logic [2:0] rb_src_reg;
    logic [2:0] rb_dst_reg;
    logic [7:0] rb_input_bus;
    logic [7:0] rb_output_bus;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ref_regs [6] = '{default: 8'h00};

    register_block_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_REGS(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_src         (cmd_src),
        .cmd_dst         (cmd_dst),
        .cmd_imm         (cmd_imm),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_error       (rsp_error),
        .rb_write_enable (rb_write_enable),
        .rb_read_enable  (rb_read_enable),
        .rb_src_reg      (rb_src_reg),
        .rb_dst_reg      (rb_dst_reg),
        .rb_input_bus    (rb_input_bus),
        .rb_output_bus   (rb_output_bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- attached register block (registered read port) ----------------
    logic [7:0] blk_regs [6] = '{default: 8'h00};
    logic [7:0] blk_out_q    = 8'h00;
    logic       blk_out_vld  = 1'b0;

    always @(posedge clk) begin
        if (rb_write_enable && rb_dst_reg < 3'd6) blk_regs[rb_dst_reg] <= rb_input_bus;
        blk_out_vld <= rb_read_enable;
        if (rb_read_enable && rb_src_reg < 3'd6) blk_out_q <= blk_regs[rb_src_reg];
    end
    // Outside the valid window the bus carries inverted data so mistimed capture shows.
    assign rb_output_bus = blk_out_vld ? blk_out_q : ~blk_out_q;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                         input logic [7:0] imm, output logic [7:0] e_data, output logic e_err,
                         output int e_lat, output int e_wr, output int e_rd);
        bit src_bad = (src >= 3'd6);
        bit dst_bad = (dst >= 3'd6);
        e_data = 8'h00; e_err = 1'b0; e_lat = 1; e_wr = 0; e_rd = 0;
        case (op)
            2'b01: e_err = dst_bad;
            2'b10: e_err = src_bad || dst_bad;
            2'b11: e_err = src_bad;
            default: e_err = 1'b0;
        endcase
        if (!e_err) begin
            case (op)
                2'b01: begin e_data = imm; e_lat = 2; e_wr = 1; ref_regs[dst] = imm; end
                2'b10: begin e_data = ref_regs[src]; e_lat = 4; e_wr = 1; e_rd = 1; ref_regs[dst] = e_data; end
                2'b11: begin e_data = ref_regs[src]; e_lat = 3; e_rd = 1; end
                default: ;
            endcase
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 6; i++) check(tag, 32'(blk_regs[i]), 32'(ref_regs[i]));
    endtask

    // ---------------- driver: one full command with response back-pressure ----------------
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                           input logic [7:0] imm, input int hold);
        logic [7:0] e_data;
        logic       e_err;
        int         e_lat, e_wr, e_rd, lat, wr_cnt, rd_cnt;
        bit         got;
        model(op, src, dst, imm, e_data, e_err, e_lat, e_wr, e_rd);
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm;
        @(posedge clk);
        lat = 0; wr_cnt = 0; rd_cnt = 0; got = 0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge clk);
            // Garbage on the command port while busy must be ignored.
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_src   = 3'($urandom_range(0, 7));
            cmd_dst   = 3'($urandom_range(0, 7));
            cmd_imm   = 8'($urandom_range(0, 255));
            if (rsp_valid) begin
                got = 1; lat = c;
            end else begin
                check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
                if (rb_write_enable) begin
                    wr_cnt++;
                    check("wr_dst", 32'(rb_dst_reg), 32'(dst));
                    check("wr_data", 32'(rb_input_bus), 32'(e_data));
                end
                if (rb_read_enable) begin
                    rd_cnt++;
                    check("rd_src", 32'(rb_src_reg), 32'(src));
                end
            end
        end
        check("latency", 32'(lat), 32'(e_lat));
        check("write_pulses", 32'(wr_cnt), 32'(e_wr));
        check("read_pulses", 32'(rd_cnt), 32'(e_rd));
        for (int h = 0; h <= hold; h++) begin
            check("rsp_valid", 32'(rsp_valid), 32'd1);
            check("rsp_data", 32'(rsp_data), 32'(e_data));
            check("rsp_error", 32'(rsp_error), 32'(e_err));
            check("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("rsp_no_strobe", 32'({rb_write_enable, rb_read_enable}), 32'd0);
            if (h < hold) @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_hs_valid", 32'(rsp_valid), 32'd0);
        check("post_hs_ready", 32'(cmd_ready), 32'd1);
        check_regs("regs");
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] imm_v;
        logic [7:0] e_data;
        logic       e_err;
        int         e_lat, e_wr, e_rd;

        // Reset state
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_outputs", 32'({rsp_valid, rsp_error, rb_write_enable, rb_read_enable}), 32'd0);
        check("rst_buses", 32'({rsp_data, rb_src_reg, rb_dst_reg, rb_input_bus}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // Directed cases
        run_cmd(2'b01, 3'd0, 3'd3, 8'hA5, 0);
        run_cmd(2'b01, 3'd0, 3'd1, 8'h3C, 0);
        run_cmd(2'b10, 3'd1, 3'd2, 8'h00, 0);
        run_cmd(2'b11, 3'd1, 3'd0, 8'h00, 5);
        run_cmd(2'b01, 3'd0, 3'd6, 8'hFF, 1);
        run_cmd(2'b10, 3'd7, 3'd0, 8'h00, 0);
        run_cmd(2'b11, 3'd6, 3'd0, 8'h00, 0);
        run_cmd(2'b00, 3'd7, 3'd7, 8'h55, 2);
        run_cmd(2'b10, 3'd2, 3'd2, 8'h00, 0);

        // Reset during CAP of MOVE 1->4 aborts it
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_src = 3'd1; cmd_dst = 3'd4;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort_rd", 32'(rb_read_enable), 32'd1);
        @(negedge clk);
        check("abort_cap", 32'({rb_read_enable, rb_write_enable, rsp_valid}), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_rst_ready", 32'(cmd_ready), 32'd0);
        check("abort_rst_outs", 32'({rsp_valid, rsp_error, rb_write_enable, rb_read_enable}), 32'd0);
        check("abort_rst_buses", 32'({rsp_data, rb_src_reg, rb_dst_reg, rb_input_bus}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_idle_ready", 32'(cmd_ready), 32'd1);
            check("abort_no_rsp", 32'({rsp_valid, rb_write_enable, rb_read_enable}), 32'd0);
        end
        check_regs("abort_regs");

        // Back-to-back LOADs with cmd_valid held and rsp_ready tied high
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("b2b_ready", 32'(cmd_ready), 32'd1);
            imm_v = 8'($urandom_range(0, 255));
            cmd_op = 2'b01; cmd_src = 3'd0; cmd_dst = 3'(k); cmd_imm = imm_v;
            model(2'b01, 3'd0, 3'(k), imm_v, e_data, e_err, e_lat, e_wr, e_rd);
            @(negedge clk);
            check("b2b_wr_busy", 32'({cmd_ready, rb_write_enable}), 32'b01);
            check("b2b_wr_dst", 32'(rb_dst_reg), 32'(k));
            @(negedge clk);
            check("b2b_rsp_busy", 32'({cmd_ready, rsp_valid}), 32'b01);
            check("b2b_rsp_data", 32'(rsp_data), 32'(e_data));
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        check("b2b_end_ready", 32'(cmd_ready), 32'd1);
        check_regs("b2b_regs");

        // Randomized commands
        for (int n = 0; n < 80; n++) begin
            logic [2:0] s, d;
            s = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            d = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            run_cmd(2'($urandom_range(0, 3)), s, d, 8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_block_sequencer.md
Name: register_block_sequencer

Overview:
- Command-driven master for the 6x8-bit register block. It accepts one register-transfer command per handshake and drives the block's port-side signals with correct timing.
- The block's read port is registered, so this sequencer handles the read latency on its behalf.
- Sits between the control logic and the register block; rb_* outputs wire directly to the block's write_enable, read_enable, src_reg, dst_reg and input_bus; rb_output_bus wires from its output_bus.
- Results are returned on a valid/ready response channel.

Parameters:
- DATA_WIDTH, 8, register and bus width.
- ADDR_WIDTH, 3, register index width.
- NUM_REGS, 6, number of implemented registers; valid indices are 0..NUM_REGS-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  2  00 NOP, 01 LOAD (imm->dst), 10 MOVE (src->dst), 11 READ (src->rsp).
- cmd_src  input  ADDR_WIDTH  source register index.
- cmd_dst  input  ADDR_WIDTH  destination register index.
- cmd_imm  input  DATA_WIDTH  immediate for LOAD.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  DATA_WIDTH  value written (LOAD/MOVE), value read (READ), 0 (NOP/error).
- rsp_error  output  1  command rejected (index out of range).
- rb_write_enable  output  1  to register block write_enable.
- rb_read_enable  output  1  to register block read_enable.
- rb_src_reg  output  ADDR_WIDTH  to register block src_reg.
- rb_dst_reg  output  ADDR_WIDTH  to register block dst_reg.
- rb_input_bus  output  DATA_WIDTH  to register block input_bus.
- rb_output_bus  input  DATA_WIDTH  from register block output_bus.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE immediately.
  - Latched op/src/dst/data registers and all outputs go to 0: cmd_ready=0 while rst is high, =1 in IDLE after release; rsp_valid=0, rsp_data=0, rsp_error=0, all rb_* outputs 0.
  - Reset mid-operation aborts the command: no write is issued and no response is produced.
- FSM states: IDLE, RD, CAP, WR, RSP. All outputs are Moore-decoded from the state and the latched command fields.
- IDLE:
  - cmd_ready=1. On cmd_valid&cmd_ready, latch op/src/dst/imm.
  - Error check: an index used by the op (dst for LOAD; src and dst for MOVE; src for READ) that is >= NUM_REGS sets the error flag. The sequencer then goes to RSP with rsp_error=1, rsp_data=0, and makes no rb_* activity.
  - Next state: NOP->RSP; LOAD->WR with data=imm; MOVE->RD; READ->RD.
- RD (1 cycle): rb_read_enable=1, rb_src_reg=src. The register block updates output_bus at the end of this cycle. Next state: CAP.
- CAP (1 cycle): rb_read_enable=0. Sample rb_output_bus into the data register at the closing edge, before the block tri-states. Next state: WR for MOVE, RSP for READ.
- WR (1 cycle): rb_write_enable=1, rb_dst_reg=dst, rb_input_bus=data. The write commits at the closing edge. Next state: RSP.
- RSP:
  - rsp_valid=1, with rsp_data/rsp_error held stable until rsp_ready.
  - On rsp_valid&rsp_ready: clear to IDLE; cmd_ready rises the following cycle (no back-to-back overlap).
- Outside their states: rb_write_enable=0, rb_read_enable=0. rb_src_reg, rb_dst_reg and rb_input_bus hold the latched values (no glitch requirement beyond synchronous).
- Latency, cycles from the accept edge to rsp_valid high:
  - NOP and error: 1.
  - LOAD: 2.
  - READ: 3.
  - MOVE with src==dst: 4. This is a legal no-op rewrite of the same value.
- Exactly one rb_write_enable pulse per LOAD/MOVE. Zero write pulses for READ, NOP and errors.
- cmd_* inputs are ignored whenever cmd_ready=0.

Test Plan:
- Reset with the register block attached, then LOAD dst=3 imm=0xA5 → rb_write_enable high for exactly 1 cycle, 1 cycle after accept; register 3 = 0xA5; rsp_valid at +2 with rsp_data=0xA5, rsp_error=0.
- LOAD r1=0x3C, then MOVE src=1 dst=2 → RD, CAP, WR sequence observed; r2 output = 0x3C; rsp_data=0x3C at accept+4.
- READ src=1 after the above, with rsp_ready held low 5 cycles → rsp_valid and rsp_data=0x3C stable for all 5 cycles; cmd_ready=0 throughout; cmd_ready rises the cycle after the handshake.
- LOAD dst=6 imm=0xFF, and MOVE src=7 dst=0 → rsp_error=1, rsp_data=0 at accept+1; no rb_write_enable or rb_read_enable pulse; registers unchanged.
- Assert rst during the CAP cycle of a MOVE 1→4 → outputs 0 asynchronously; no write to r4; after release cmd_ready=1 and no stray rsp_valid.
- Back-to-back LOADs with cmd_valid held high and rsp_ready tied high → each command accepted only in IDLE; 3 cycles per LOAD; register values match the issued order.
